// File: rtl/t5_lsu_if.sv
// Data-side Wishbone-style bus between the load/store unit and memory.
interface t5_lsu_if;
    logic [31:0] dwb_adr_o;
    logic [31:0] dwb_dat_o;
    logic [3:0]  dwb_sel_o;
    logic        dwb_we_o;
    logic        dwb_stb_o;
    logic        dwb_cyc_o;
    logic [31:0] dwb_dat_i;
    logic        dwb_ack_i;

    modport master (
        output dwb_adr_o, dwb_dat_o, dwb_sel_o, dwb_we_o, dwb_stb_o, dwb_cyc_o,
        input  dwb_dat_i, dwb_ack_i
    );

    modport slave (
        input  dwb_adr_o, dwb_dat_o, dwb_sel_o, dwb_we_o, dwb_stb_o, dwb_cyc_o,
        output dwb_dat_i, dwb_ack_i
    );
endinterface

// File: rtl/t5_lsu.sv
// Load/store unit: one bus transaction per LOAD/STORE with a stall, a bus
// timeout, a misalignment pulse and load-data lane extraction.
module t5_lsu #(
    parameter logic [7:0] TOUT = 8'd255
) (
    input  logic        sclk,
    input  logic        srst_n,
    input  logic [4:0]  xopc,
    input  logic [2:0]  xfn3,
    input  logic [31:0] xbpc,
    input  logic [31:0] xdat,
    input  logic [31:0] malu,
    t5_lsu_if.master    dwb,
    output logic        lstl,
    output logic [31:0] mdat,
    output logic [4:0]  mopc,
    output logic        mmis,
    output logic        mberr
);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] mdat_q, mdat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic [1:0]  lane_q, lane_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  mopc_q, mopc_d;
    logic        mmis_q, mmis_d;
    logic        mberr_q, mberr_d;

    logic is_load_s, is_store_s, is_mem_s, mis_s, lreq_s;
    logic busy_s, ack_s, timeout_s, lstl_s;

    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] ofs);
        case (size)
            2'b00:   lane_sel = 4'b0001 << ofs;
            2'b01:   lane_sel = ofs[1] ? 4'b1100 : 4'b0011;
            default: lane_sel = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] fmt_load(input logic [31:0] rd, input logic [2:0] fn3,
                                             input logic [1:0] ofs);
        logic [7:0]  b;
        logic [15:0] h;
        case (ofs)
            2'b00:   b = rd[7:0];
            2'b01:   b = rd[15:8];
            2'b10:   b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = ofs[1] ? rd[31:16] : rd[15:0];
        case (fn3[1:0])
            2'b00:   fmt_load = fn3[2] ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   fmt_load = fn3[2] ? {16'h0000, h} : {{16{h[15]}}, h};
            default: fmt_load = rd;
        endcase
    endfunction

    // Opcode decode, alignment check, timeout detection and the stall.
    always_comb begin
        is_load_s  = (xopc == 5'b00000);
        is_store_s = (xopc == 5'b01000);
        is_mem_s   = is_load_s | is_store_s;
        mis_s      = ((xfn3[1:0] == 2'b01) & xbpc[0]) |
                     ((xfn3[1:0] == 2'b10) & (xbpc[1:0] != 2'b00));
        lreq_s     = is_mem_s & ~mis_s;
        busy_s     = (state_q == ST_BUSY);
        ack_s      = busy_s & dwb.dwb_ack_i;
        timeout_s  = busy_s & ~dwb.dwb_ack_i & (cnt_q == TOUT);
        lstl_s     = (~busy_s & lreq_s) | (busy_s & ~dwb.dwb_ack_i & ~timeout_s);
    end

    // Next-state and next-output computation for the IDLE/BUSY sequencer.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        mdat_d  = mdat_q;
        mmis_d  = 1'b0;
        mberr_d = 1'b0;
        mopc_d  = lstl_s ? mopc_q : xopc;
        case (state_q)
            ST_IDLE: begin
                if (lreq_s) begin
                    state_d = ST_BUSY;
                    adr_d   = {xbpc[31:2], 2'b00};
                    dat_d   = xdat;
                    sel_d   = lane_sel(xfn3[1:0], xbpc[1:0]);
                    we_d    = is_store_s;
                    lane_d  = xbpc[1:0];
                    cnt_d   = 8'd0;
                end else begin
                    mdat_d = malu;
                    mmis_d = is_mem_s & mis_s;
                end
            end
            ST_BUSY: begin
                // An acknowledge in the timeout cycle still completes the access.
                if (ack_s) begin
                    state_d = ST_IDLE;
                    if (!we_q) begin
                        mdat_d = fmt_load(dwb.dwb_dat_i, xfn3, lane_q);
                    end else begin
                        mdat_d = mdat_q;
                    end
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                    mberr_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any bus cycle in flight.
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            state_q <= ST_IDLE;
            adr_q   <= 32'h0000_0000;
            dat_q   <= 32'h0000_0000;
            sel_q   <= 4'b0000;
            we_q    <= 1'b0;
            lane_q  <= 2'b00;
            cnt_q   <= 8'd0;
            mdat_q  <= 32'h0000_0000;
            mopc_q  <= 5'h0D;
            mmis_q  <= 1'b0;
            mberr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            mdat_q  <= mdat_d;
            mopc_q  <= mopc_d;
            mmis_q  <= mmis_d;
            mberr_q <= mberr_d;
        end
    end

    assign dwb.dwb_adr_o = adr_q;
    assign dwb.dwb_dat_o = dat_q;
    assign dwb.dwb_sel_o = sel_q;
    assign dwb.dwb_we_o  = we_q;
    assign dwb.dwb_cyc_o = busy_s;
    assign dwb.dwb_stb_o = busy_s;
    assign lstl          = lstl_s;
    assign mdat          = mdat_q;
    assign mopc          = mopc_q;
    assign mmis          = mmis_q;
    assign mberr         = mberr_q;

endmodule

// File: tb/tb_t5_lsu.sv
// Self-checking bench for t5_lsu: directed vector table, corner sequences
// and random operations against a transaction-level reference model.
module tb_t5_lsu;
    localparam int TO = 4;

    logic        sclk = 1'b0;
    logic        srst_n = 1'b0;
    logic [4:0]  xopc;
    logic [2:0]  xfn3;
    logic [31:0] xbpc, xdat, malu;
    logic        lstl;
    logic [31:0] mdat;
    logic [4:0]  mopc;
    logic        mmis, mberr;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl_mdat;

    t5_lsu_if bus ();

    t5_lsu #(.TOUT(8'd4)) dut (
        .sclk  (sclk),
        .srst_n(srst_n),
        .xopc  (xopc),
        .xfn3  (xfn3),
        .xbpc  (xbpc),
        .xdat  (xdat),
        .malu  (malu),
        .dwb   (bus),
        .lstl  (lstl),
        .mdat  (mdat),
        .mopc  (mopc),
        .mmis  (mmis),
        .mberr (mberr)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        logic [4:0]  opc;
        logic [2:0]  fn3;
        logic [31:0] adr, wd, alu, rd;
        int          ackd;
        logic        e_cyc;
        logic [31:0] e_adr;
        logic [3:0]  e_sel;
        logic        e_we;
        int          e_stl;
        logic [31:0] e_mdat;
        logic        e_mis, e_berr;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [4:0] opc, input logic [2:0] fn3,
                                 input logic [31:0] adr, wd, alu, rd, input int ackd,
                                 input logic e_cyc, input logic [31:0] e_adr,
                                 input logic [3:0] e_sel, input logic e_we, input int e_stl,
                                 input logic [31:0] e_mdat, input logic e_mis, e_berr);
        vec_t v;
        v.opc = opc; v.fn3 = fn3; v.adr = adr; v.wd = wd; v.alu = alu; v.rd = rd;
        v.ackd = ackd; v.e_cyc = e_cyc; v.e_adr = e_adr; v.e_sel = e_sel; v.e_we = e_we;
        v.e_stl = e_stl; v.e_mdat = e_mdat; v.e_mis = e_mis; v.e_berr = e_berr;
        return v;
    endfunction

    // Reference load formatting: shift the wanted lane to the top, then shift back down.
    function automatic logic [31:0] ref_fmt(input logic [31:0] rd, input logic [2:0] fn3,
                                            input logic [1:0] lane);
        int          ln;
        logic [31:0] t;
        ln = int'(lane);
        if (fn3[1:0] == 2'b00) begin
            t = rd << (8 * (3 - ln));
            return fn3[2] ? (t >> 24) : 32'($signed(t) >>> 24);
        end else if (fn3[1:0] == 2'b01) begin
            t = rd << (16 * (1 - ln / 2));
            return fn3[2] ? (t >> 16) : 32'($signed(t) >>> 16);
        end
        return rd;
    endfunction

    function automatic vec_t model(input vec_t v, input logic [31:0] prev);
        vec_t r;
        bit   mem, mis, tmo;
        r     = v;
        mem   = (v.opc == 5'd0) || (v.opc == 5'd8);
        mis   = ((v.fn3[1:0] == 2'b01) && v.adr[0]) ||
                ((v.fn3[1:0] == 2'b10) && (v.adr[1:0] != 2'b00));
        r.e_adr = v.adr & 32'hFFFF_FFFC;
        r.e_we  = (v.opc == 5'd8);
        if (v.fn3[1:0] == 2'b00)      r.e_sel = 4'(1 << v.adr[1:0]);
        else if (v.fn3[1:0] == 2'b01) r.e_sel = v.adr[1] ? 4'hC : 4'h3;
        else                          r.e_sel = 4'hF;
        if (!mem || mis) begin
            r.e_cyc = 1'b0; r.e_stl = 0; r.e_mdat = v.alu; r.e_mis = mem; r.e_berr = 1'b0;
        end else begin
            tmo     = (v.ackd < 0) || (v.ackd > TO);
            r.e_cyc = 1'b1;
            r.e_stl = tmo ? TO + 1 : v.ackd + 1;
            r.e_berr = tmo;
            r.e_mis = 1'b0;
            r.e_mdat = (tmo || r.e_we) ? prev : ref_fmt(v.rd, v.fn3, v.adr[1:0]);
        end
        return r;
    endfunction

    // Starts and ends just after a rising edge; acks at BUSY cycle index v.ackd.
    task automatic run_op(input vec_t v);
        int stl = 0;
        int busy = 0;
        bit seen = 0;
        bit done = 0;
        xopc = v.opc; xfn3 = v.fn3; xbpc = v.adr; xdat = v.wd; malu = v.alu;
        bus.dwb_dat_i = v.rd;
        bus.dwb_ack_i = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (bus.dwb_cyc_o) begin
                if (!seen) begin
                    seen = 1;
                    chk("bus_stb", bus.dwb_stb_o, 1'b1);
                    chk("bus_adr", bus.dwb_adr_o, v.e_adr);
                    chk("bus_sel", bus.dwb_sel_o, v.e_sel);
                    chk("bus_we",  bus.dwb_we_o,  v.e_we);
                    chk("bus_dat", bus.dwb_dat_o, v.wd);
                end
                bus.dwb_ack_i = (busy == v.ackd);
                busy++;
            end else begin
                bus.dwb_ack_i = 1'b0;
            end
            @(negedge sclk);
            if (lstl) stl++;
            else done = 1;
            @(posedge sclk);
            #1;
        end
        bus.dwb_ack_i = 1'b0;
        if (!done) begin
            errors++;
            $display("FAIL op_bound actual=stuck required=completion");
        end
        chk("stall_cycles", stl, v.e_stl);
        chk("busy_cycles", busy, v.e_cyc ? v.e_stl : 0);
        chk("bus_used", seen, v.e_cyc);
        chk("cyc_after", bus.dwb_cyc_o, 1'b0);
        chk("mdat", mdat, v.e_mdat);
        chk("mopc", mopc, v.opc);
        chk("mmis", mmis, v.e_mis);
        chk("mberr", mberr, v.e_berr);
    endtask

    vec_t tbl[15];
    vec_t r;
    int   k;
    logic [2:0] ld_fn[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    initial begin
        tbl[0]  = mkv(5'h00, 3'b010, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 3,
                      1'b1, 32'h100, 4'hF, 1'b0, 4, 32'hDEADBEEF, 1'b0, 1'b0);
        tbl[1]  = mkv(5'h00, 3'b000, 32'h103, 32'h0, 32'h0, 32'h80000000, 0,
                      1'b1, 32'h100, 4'h8, 1'b0, 1, 32'hFFFFFF80, 1'b0, 1'b0);
        tbl[2]  = mkv(5'h00, 3'b100, 32'h103, 32'h0, 32'h0, 32'h80000000, 0,
                      1'b1, 32'h100, 4'h8, 1'b0, 1, 32'h00000080, 1'b0, 1'b0);
        tbl[3]  = mkv(5'h08, 3'b001, 32'h202, 32'h12341234, 32'h0, 32'h0, 0,
                      1'b1, 32'h200, 4'hC, 1'b1, 1, 32'h00000080, 1'b0, 1'b0);
        tbl[4]  = mkv(5'h00, 3'b010, 32'h101, 32'h0, 32'hA5A50001, 32'h0, 0,
                      1'b0, 32'h0, 4'h0, 1'b0, 0, 32'hA5A50001, 1'b1, 1'b0);
        tbl[5]  = mkv(5'h0C, 3'b000, 32'h0, 32'h0, 32'h11112222, 32'h0, 0,
                      1'b0, 32'h0, 4'h0, 1'b0, 0, 32'h11112222, 1'b0, 1'b0);
        tbl[6]  = mkv(5'h00, 3'b001, 32'h106, 32'h0, 32'h0, 32'h80017FFF, 1,
                      1'b1, 32'h104, 4'hC, 1'b0, 2, 32'hFFFF8001, 1'b0, 1'b0);
        tbl[7]  = mkv(5'h00, 3'b101, 32'h104, 32'h0, 32'h0, 32'h8001F00F, 2,
                      1'b1, 32'h104, 4'h3, 1'b0, 3, 32'h0000F00F, 1'b0, 1'b0);
        tbl[8]  = mkv(5'h08, 3'b000, 32'h301, 32'h5A5A5A5A, 32'h0, 32'h0, 0,
                      1'b1, 32'h300, 4'h2, 1'b1, 1, 32'h0000F00F, 1'b0, 1'b0);
        tbl[9]  = mkv(5'h00, 3'b000, 32'h102, 32'h0, 32'h0, 32'h00123456, 0,
                      1'b1, 32'h100, 4'h4, 1'b0, 1, 32'h00000012, 1'b0, 1'b0);
        tbl[10] = mkv(5'h08, 3'b010, 32'h402, 32'h0, 32'hCAFEF00D, 32'h0, 0,
                      1'b0, 32'h0, 4'h0, 1'b0, 0, 32'hCAFEF00D, 1'b1, 1'b0);
        tbl[11] = mkv(5'h00, 3'b001, 32'h401, 32'h0, 32'h0BAD0BAD, 32'h0, 0,
                      1'b0, 32'h0, 4'h0, 1'b0, 0, 32'h0BAD0BAD, 1'b1, 1'b0);
        tbl[12] = mkv(5'h00, 3'b010, 32'h600, 32'h0, 32'h0, 32'h13572468, 4,
                      1'b1, 32'h600, 4'hF, 1'b0, 5, 32'h13572468, 1'b0, 1'b0);
        tbl[13] = mkv(5'h00, 3'b010, 32'h700, 32'h0, 32'h0, 32'h0, -1,
                      1'b1, 32'h700, 4'hF, 1'b0, 5, 32'h13572468, 1'b0, 1'b1);
        tbl[14] = mkv(5'h0C, 3'b000, 32'h0, 32'h0, 32'h00000042, 32'h0, 0,
                      1'b0, 32'h0, 4'h0, 1'b0, 0, 32'h00000042, 1'b0, 1'b0);

        xopc = 5'h0C; xfn3 = 3'b000; xbpc = 32'h0; xdat = 32'h0; malu = 32'h0;
        bus.dwb_ack_i = 1'b0; bus.dwb_dat_i = 32'h0;

        #12;
        chk("rst_cyc", bus.dwb_cyc_o, 1'b0);
        chk("rst_stb", bus.dwb_stb_o, 1'b0);
        chk("rst_we",  bus.dwb_we_o,  1'b0);
        chk("rst_sel", bus.dwb_sel_o, 4'h0);
        chk("rst_adr", bus.dwb_adr_o, 32'h0);
        chk("rst_dat", bus.dwb_dat_o, 32'h0);
        chk("rst_mdat", mdat, 32'h0);
        chk("rst_mmis", mmis, 1'b0);
        chk("rst_mberr", mberr, 1'b0);
        chk("rst_mopc", mopc, 5'h0D);
        chk("rst_lstl", lstl, 1'b0);
        @(negedge sclk);
        srst_n = 1'b1;
        @(posedge sclk);
        #1;

        for (int i = 0; i < 15; i++) begin
            run_op(tbl[i]);
        end
        mdl_mdat = 32'h00000042;

        // Acknowledge while idle must be ignored.
        xopc = 5'h0C; malu = 32'h00000099; bus.dwb_ack_i = 1'b1;
        @(posedge sclk);
        #1;
        chk("idle_ack_cyc", bus.dwb_cyc_o, 1'b0);
        chk("idle_ack_mdat", mdat, 32'h00000099);
        chk("idle_ack_lstl", lstl, 1'b0);
        bus.dwb_ack_i = 1'b0;

        // Reset between edges while BUSY, then a late acknowledge after release.
        xopc = 5'h00; xfn3 = 3'b010; xbpc = 32'h500;
        @(posedge sclk);
        #1;
        chk("mid_busy_cyc", bus.dwb_cyc_o, 1'b1);
        #2;
        srst_n = 1'b0;
        #1;
        chk("mid_rst_cyc", bus.dwb_cyc_o, 1'b0);
        chk("mid_rst_stb", bus.dwb_stb_o, 1'b0);
        chk("mid_rst_mopc", mopc, 5'h0D);
        chk("mid_rst_mberr", mberr, 1'b0);
        xopc = 5'h0C; malu = 32'h00000077; bus.dwb_ack_i = 1'b1;
        @(negedge sclk);
        srst_n = 1'b1;
        @(posedge sclk);
        #1;
        chk("late_ack_cyc", bus.dwb_cyc_o, 1'b0);
        chk("late_ack_mdat", mdat, 32'h00000077);
        chk("late_ack_mberr", mberr, 1'b0);
        @(posedge sclk);
        #1;
        chk("late_ack_cyc2", bus.dwb_cyc_o, 1'b0);
        chk("late_ack_mberr2", mberr, 1'b0);
        bus.dwb_ack_i = 1'b0;
        mdl_mdat = 32'h00000077;

        for (int n = 0; n < 200; n++) begin
            k = int'($urandom_range(0, 9));
            r.adr = $urandom();
            r.wd  = $urandom();
            r.alu = $urandom();
            r.rd  = $urandom();
            r.ackd = int'($urandom_range(0, 7)) - 1;
            if (k < 4) begin
                r.opc = 5'h00;
                r.fn3 = ld_fn[$urandom_range(0, 4)];
            end else if (k < 7) begin
                r.opc = 5'h08;
                r.fn3 = 3'($urandom_range(0, 2));
            end else begin
                r.opc = 5'($urandom_range(1, 31));
                if (r.opc == 5'h08) r.opc = 5'h0C;
                r.fn3 = 3'($urandom_range(0, 7));
            end
            r = model(r, mdl_mdat);
            run_op(r);
            mdl_mdat = r.e_mdat;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
